// File: rtl/vga_pixel_renderer_if.sv
// Framebuffer read bus between the pixel renderer (master) and the
// down-scaled framebuffer BRAM (slave). fb_data is valid 1 clk after fb_rd.
interface vga_pixel_renderer_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd;
  logic [11:0]       fb_data;

  modport master (output fb_addr, output fb_rd, input fb_data);
  modport slave  (input fb_addr, input fb_rd, output fb_data);
endinterface

// File: rtl/vga_pixel_renderer.sv
// VGA pixel renderer: detects pixel ticks from the timing counters, fetches
// each pixel from a down-scaled framebuffer, optionally overlays one solid
// square sprite, and drives RGB and syncs with matching 2-clk alignment.
// Optional feature macro: VGA_SPRITE_EN (sprite registers, hit compare, mux).
module vga_pixel_renderer #(
  parameter int H_OFS    = 145,
  parameter int V_OFS    = 35,
  parameter int SCALE    = 2,
  parameter int FB_W     = 160,
  parameter int ADDR_W   = 15,
  parameter int SPR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hCount,
  input  logic [9:0]           vCount,
  input  logic                 bright,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  vga_pixel_renderer_if.master fb,
  input  logic                 spr_we,
  input  logic [9:0]           spr_x,
  input  logic [9:0]           spr_y,
  input  logic [11:0]          spr_color,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 frame_start
);

  logic [9:0]  h_prev;
  logic        tick;
  logic        frame_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [16:0] addr_full;

  logic        bright_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic        tick_d1;
  logic        tick_d2;
  logic [11:0] pixel;

  // The timing counters only move every 4 clk, so a change in hCount marks a new pixel.
  assign tick       = (hCount != h_prev);
  assign frame_tick = tick && (hCount == 10'd0) && (vCount == 10'd0);
  assign x          = hCount - 10'(H_OFS);
  assign y          = vCount - 10'(V_OFS);
  assign addr_full  = 17'(y >> SCALE) * 17'(FB_W) + 17'(x >> SCALE);

  // Previous hCount for tick detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) h_prev <= 10'd0;
    else        h_prev <= hCount;
  end

  // Stage 1: issue the framebuffer read and capture per-pixel context on each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb.fb_addr <= '0;
      fb.fb_rd   <= 1'b0;
      bright_s1  <= 1'b0;
      hs_s1      <= 1'b1;
      vs_s1      <= 1'b1;
    end else if (tick) begin
      // Blanked pixels skip the read and leave the address where it was.
      if (bright) fb.fb_addr <= addr_full[ADDR_W-1:0];
      fb.fb_rd  <= bright;
      bright_s1 <= bright;
      hs_s1     <= hsync_in;
      vs_s1     <= vsync_in;
    end else begin
      fb.fb_rd  <= 1'b0;
    end
  end

  // Delay the tick to line up with the BRAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_d1 <= 1'b0;
      tick_d2 <= 1'b0;
    end else begin
      tick_d1 <= tick;
      tick_d2 <= tick_d1;
    end
  end

  // One-clk marker for the first tick of each frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_start <= 1'b0;
    else        frame_start <= frame_tick;
  end

`ifdef VGA_SPRITE_EN
  logic [9:0]  x_s1;
  logic [9:0]  y_s1;
  logic [9:0]  sh_x;
  logic [9:0]  sh_y;
  logic [11:0] sh_c;
  logic [9:0]  ac_x;
  logic [9:0]  ac_y;
  logic [11:0] ac_c;
  logic        spr_hit;
  logic        unused_bits;

  // Screen position of the pixel in flight, for the sprite compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_s1 <= 10'd0;
      y_s1 <= 10'd0;
    end else if (tick) begin
      x_s1 <= x;
      y_s1 <= y;
    end
  end

  // Shadow registers accept host writes at any time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_x <= 10'd0;
      sh_y <= 10'd0;
      sh_c <= 12'h000;
    end else if (spr_we) begin
      sh_x <= spr_x;
      sh_y <= spr_y;
      sh_c <= spr_color;
    end
  end

  // Active registers change only at frame start, so a frame never tears;
  // a write landing on that same clk is still in flight to the shadow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ac_x <= 10'd0;
      ac_y <= 10'd0;
      ac_c <= 12'h000;
    end else if (frame_tick) begin
      ac_x <= sh_x;
      ac_y <= sh_y;
      ac_c <= sh_c;
    end
  end

  // 11-bit bounds so a sprite near the 1023 edge does not wrap.
  assign spr_hit = (ac_c != 12'h000) &&
                   ({1'b0, x_s1} >= {1'b0, ac_x}) &&
                   ({1'b0, x_s1} <= ({1'b0, ac_x} + 11'(SPR_SIZE - 1))) &&
                   ({1'b0, y_s1} >= {1'b0, ac_y}) &&
                   ({1'b0, y_s1} <= ({1'b0, ac_y} + 11'(SPR_SIZE - 1)));
  assign pixel       = spr_hit ? ac_c : fb.fb_data;
  assign unused_bits = ^{addr_full, x, y};
`else
  logic unused_bits;

  assign pixel       = fb.fb_data;
  assign unused_bits = ^{addr_full, x, y, spr_we, spr_x, spr_y, spr_color};
`endif

  // Stage 2: register colour and syncs together so they stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r   <= 4'h0;
      vga_g   <= 4'h0;
      vga_b   <= 4'h0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else if (tick_d2) begin
      {vga_r, vga_g, vga_b} <= bright_s1 ? pixel : 12'h000;
      hsync_o <= hs_s1;
      vsync_o <= vs_s1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// Self-checking bench for vga_pixel_renderer with a scoreboard queue.
// Builds with or without VGA_SPRITE_EN; sprite expectations follow the macro.
module tb_vga_pixel_renderer;

`ifdef VGA_SPRITE_EN
  localparam bit SPR_ON = 1'b1;
`else
  localparam bit SPR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hCount, vCount;
  logic        bright, hsync_in, vsync_in;
  logic        spr_we;
  logic [9:0]  spr_x, spr_y;
  logic [11:0] spr_color;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_o, vsync_o, frame_start;

  int checks = 0;
  int errors = 0;

  logic [13:0] sb[$];
  int          last_addr;
  logic [11:0] last_rgb;
  logic        last_hs, last_vs;

  vga_pixel_renderer_if #(.ADDR_W(15)) fbif ();

  vga_pixel_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .fb         (fbif),
    .spr_we     (spr_we),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_color  (spr_color),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] fb_word(input int a);
    if (a == 0) return 12'hABC;
    return 12'((a * 37 + 5) ^ (a >> 3));
  endfunction

  // Framebuffer BRAM model: 1-clk synchronous read.
  always @(posedge clk) if (fbif.fb_rd) fbif.fb_data <= fb_word(int'(fbif.fb_addr));

  // One pixel period (4 clk) starting just after a posedge.
  task automatic drive_pix(input int h, input int v, input logic br, input logic hs,
                           input logic vs, input logic spr_exp, input logic [11:0] spr_col);
    logic [11:0] exp_rgb;
    logic [13:0] want, got;
    logic        exp_fs;
    hCount = 10'(h); vCount = 10'(v); bright = br; hsync_in = hs; vsync_in = vs;
    if (br) last_addr = ((v - 35) / 4) * 160 + (h - 145) / 4;
    exp_rgb = !br ? 12'h000 : (spr_exp ? spr_col : fb_word(last_addr));
    exp_fs  = (h == 0) && (v == 0);
    sb.push_back({exp_rgb, hs, vs});
    @(posedge clk); #1; spr_we = 1'b0;
    checks++;
    if (fbif.fb_rd !== br) begin
      errors++; $display("FAIL fb_rd_tick h=%0d v=%0d got %b want %b", h, v, fbif.fb_rd, br);
    end
    checks++;
    if (fbif.fb_addr !== 15'(last_addr)) begin
      errors++; $display("FAIL fb_addr h=%0d v=%0d got %0d want %0d", h, v, fbif.fb_addr, last_addr);
    end
    checks++;
    if (frame_start !== exp_fs) begin
      errors++; $display("FAIL frame_start h=%0d v=%0d got %b want %b", h, v, frame_start, exp_fs);
    end
    checks++;
    if ({hsync_o, vsync_o} !== {last_hs, last_vs}) begin
      errors++; $display("FAIL sync_hold_c1 h=%0d got %b%b want %b%b", h, hsync_o, vsync_o, last_hs, last_vs);
    end
    @(posedge clk); #1;
    checks++;
    if ({fbif.fb_rd, frame_start} !== 2'b00) begin
      errors++; $display("FAIL pulse_width h=%0d got rd=%b fs=%b want 0 0", h, fbif.fb_rd, frame_start);
    end
    checks++;
    if ({vga_r, vga_g, vga_b, hsync_o, vsync_o} !== {last_rgb, last_hs, last_vs}) begin
      errors++; $display("FAIL out_hold_c2 h=%0d got %h/%b%b want %h/%b%b", h,
                         {vga_r, vga_g, vga_b}, hsync_o, vsync_o, last_rgb, last_hs, last_vs);
    end
    @(posedge clk); #1;
    want = sb.pop_front();
    got  = {vga_r, vga_g, vga_b, hsync_o, vsync_o};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL pixel_out h=%0d v=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                         h, v, got[13:2], got[1], got[0], want[13:2], want[1], want[0]);
    end
    last_rgb = want[13:2]; last_hs = want[1]; last_vs = want[0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; hCount = 10'd0; vCount = 10'd0; bright = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; spr_we = 1'b0;
    spr_x = 10'd0; spr_y = 10'd0; spr_color = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if ({hsync_o, vsync_o} !== 2'b11) begin
      errors++; $display("FAIL reset_sync got %b%b want 11", hsync_o, vsync_o);
    end
    checks++;
    if ({fbif.fb_rd, frame_start} !== 2'b00 || fbif.fb_addr !== 15'd0) begin
      errors++; $display("FAIL reset_fb got rd=%b fs=%b addr=%0d want 0 0 0",
                         fbif.fb_rd, frame_start, fbif.fb_addr);
    end
    reset = 1'b1;
    last_addr = 0; last_rgb = 12'h000; last_hs = 1'b1; last_vs = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_pixel();
    drive_pix(145, 35, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic test_last_pixel();
    drive_pix(784, 514, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checks++;
    if (last_addr !== 19199) begin
      errors++; $display("FAIL max_addr_model got %0d want 19199", last_addr);
    end
    drive_pix(790, 514, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic test_hsync();
    for (int h = 92; h < 100; h++) drive_pix(h, 10, 1'b0, (h >= 96), 1'b1, 1'b0, 12'h000);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      drive_pix(200 + i * 3, 300, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 12'h000);
  endtask

  task automatic test_frame_start();
    drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(0, 5, 1'b0, 1'b1, 0, 1'b0, 12'h000);
  endtask

  task automatic test_mid_reset();
    drive_pix(400, 200, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    hCount = 10'd401; bright = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    @(posedge clk); #4;
    reset = 1'b0; #1;
    checks++;
    if ({vga_r, vga_g, vga_b, hsync_o, vsync_o} !== {12'h000, 2'b11}) begin
      errors++; $display("FAIL midreset_out got rgb=%h hs=%b vs=%b want 000 1 1",
                         {vga_r, vga_g, vga_b}, hsync_o, vsync_o);
    end
    checks++;
    if (fbif.fb_rd !== 1'b0 || fbif.fb_addr !== 15'd0) begin
      errors++; $display("FAIL midreset_fb got rd=%b addr=%0d want 0 0", fbif.fb_rd, fbif.fb_addr);
    end
    hCount = 10'd0; vCount = 10'd100; bright = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    last_addr = 0; last_rgb = 12'h000; last_hs = 1'b1; last_vs = 1'b1;
    @(posedge clk); #1;
    drive_pix(146, 36, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic spr_write(input int sx, input int sy, input logic [11:0] c);
    spr_x = 10'(sx); spr_y = 10'(sy); spr_color = c; spr_we = 1'b1;
    @(posedge clk); #1;
    spr_we = 1'b0;
  endtask

  task automatic test_sprite();
    spr_write(100, 50, 12'hF00);
    drive_pix(245, 85, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(245, 85, 1'b1, 1'b1, 1'b1, SPR_ON, 12'hF00);
    drive_pix(260, 100, 1'b1, 1'b1, 1'b1, SPR_ON, 12'hF00);
    drive_pix(261, 85, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(245, 101, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(244, 85, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    // write coinciding with the frame-start tick reaches the shadow only
    spr_x = 10'd300; spr_y = 10'd50; spr_color = 12'h0F0; spr_we = 1'b1;
    drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(445, 85, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(245, 85, 1'b1, 1'b1, 1'b1, SPR_ON, 12'hF00);
    drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(445, 85, 1'b1, 1'b1, 1'b1, SPR_ON, 12'h0F0);
    drive_pix(245, 85, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    // transparent colour never hits
    spr_write(300, 50, 12'h000);
    drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    drive_pix(445, 85, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_last_pixel();
    test_hsync();
    test_back_to_back();
    test_frame_start();
    test_mid_reset();
    test_sprite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
